// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result bundle for the pipelined adder
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_stall;
  logic [WIDTH-1:0] i_op1;
  logic [WIDTH-1:0] i_op2;
  logic             i_sub;
  logic             i_signed;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;

  modport master (
    output i_valid, i_stall, i_op1, i_op2, i_sub, i_signed,
    input  o_valid, o_result, o_carry, o_overflow
  );

  modport slave (
    input  i_valid, i_stall, i_op1, i_op2, i_sub, i_signed,
    output o_valid, o_result, o_carry, o_overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked add/sub with one carry hop per clock
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  // Layer 0 holds the captured operands; layer k+1 holds the result after chunk k.
  // Full operand words ride along every layer so each chunk meets its carry in step;
  // the result word accumulates chunks, so lower chunks are already deskewed.
  logic             v_q [0:STAGES];
  logic             c_q [0:STAGES];
  logic [WIDTH-1:0] r_q [0:STAGES];
  logic             s_q [0:STAGES-1];
  logic [WIDTH-1:0] a_q [0:STAGES-1];
  logic [WIDTH-1:0] b_q [0:STAGES-1];
  logic             ovf_q;

  logic [CHUNK:0]   sum   [0:STAGES-1];
  logic [WIDTH-1:0] r_nxt [0:STAGES-1];

  // Per-stage CHUNK+1-bit adder and the partial result word it produces
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum[k]   = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_q[k]};
      r_nxt[k] = r_q[k];
      r_nxt[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
  end

  // Pipeline advance: capture, carry hop per stage, global hold on stall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        r_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        s_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (!bus.i_stall) begin
      // subtract is op1 + ~op2 + 1; the +1 enters as the stage-0 carry
      v_q[0] <= bus.i_valid;
      a_q[0] <= bus.i_op1;
      b_q[0] <= bus.i_sub ? ~bus.i_op2 : bus.i_op2;
      c_q[0] <= bus.i_sub;
      s_q[0] <= bus.i_signed;
      r_q[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        c_q[k+1] <= sum[k][CHUNK];
        r_q[k+1] <= r_nxt[k];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_q[k-1];
      end
      // overflow: operand signs agree (after op2 inversion) but result sign differs
      ovf_q <= s_q[STAGES-1]
             & (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
             & (sum[STAGES-1][CHUNK-1] != a_q[STAGES-1][WIDTH-1]);
    end
  end

  assign bus.o_valid    = v_q[STAGES];
  assign bus.o_result   = r_q[STAGES];
  assign bus.o_carry    = c_q[STAGES];
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
module tb_pipelined_adder;
  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic        sgn;
    logic [31:0] r;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
    int          issue;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  int   stall_cnt = 0;
  logic last_stalled = 1'b0;
  exp_t exp_q[$];

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_cnt     <= edge_cnt + 1;
    last_stalled <= bus.i_stall;
    if (bus.i_stall) stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every output produced after a non-stalled edge must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && !last_stalled && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got result %h with no operation outstanding", bus.o_result);
      end else begin
        exp_t e;
        int   lat;
        e   = exp_q.pop_front();
        lat = (edge_cnt - e.issue) - (stall_cnt - e.stalls);
        check("result", bus.o_result, e.r);
        check("carry", 32'(bus.o_carry), 32'(e.c));
        check("overflow", 32'(bus.o_overflow), 32'(e.o));
        check("latency", 32'(lat), 32'(STAGES));
      end
    end
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic sg);
    exp_t   e;
    longint sa;
    longint sb;
    longint res;
    logic [32:0] u;
    sa  = $signed(a);
    sb  = $signed(b);
    res = sub ? sa - sb : sa + sb;
    if (sub) begin
      e.r = a - b;
      e.c = (a >= b);
    end else begin
      u   = {1'b0, a} + {1'b0, b};
      e.r = u[31:0];
      e.c = u[32];
    end
    e.o = sg && (res > 64'sd2147483647 || res < -64'sd2147483648);
    e.issue  = 0;
    e.stalls = 0;
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic sg, input logic [31:0] r, input logic c, input logic o);
    exp_t e;
    bus.i_valid  = 1'b1;
    bus.i_stall  = 1'b0;
    bus.i_op1    = a;
    bus.i_op2    = b;
    bus.i_sub    = sub;
    bus.i_signed = sg;
    e.r = r;
    e.c = c;
    e.o = o;
    e.issue  = edge_cnt + 1;
    e.stalls = stall_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_or_stall(input logic stall);
    bus.i_valid  = 1'b1 & stall;
    bus.i_stall  = stall;
    bus.i_op1    = $urandom;
    bus.i_op2    = $urandom;
    bus.i_sub    = 1'($urandom_range(0, 1));
    bus.i_signed = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    bus.i_stall = 1'b0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t m;
    logic [2:0] pat;
    int np;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b1};
    vecs[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
    vecs[9] = '{32'h00FF00FF, 32'h00FF0100, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};

    bus.i_valid  = 1'b0;
    bus.i_stall  = 1'b0;
    bus.i_op1    = '0;
    bus.i_op2    = '0;
    bus.i_sub    = 1'b0;
    bus.i_signed = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(bus.o_valid), 32'd0);
    check("reset_result", bus.o_result, 32'd0);
    check("reset_carry", 32'(bus.o_carry), 32'd0);
    check("reset_overflow", 32'(bus.o_overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      issue(vecs[i].op1, vecs[i].op2, vecs[i].sub, vecs[i].sgn, vecs[i].r, vecs[i].c, vecs[i].o);
    drain();

    for (int i = 0; i < 33; i++) begin
      for (int j = 0; j < 33; j++) begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic        g;
        a = 32'(i) * 32'h0FFECFD0;
        b = 32'(j) * 32'h0FFFF000;
        s = 1'((i ^ j) & 1);
        g = 1'(i & 1);
        m = model(a, b, s, g);
        issue(a, b, s, g, m.r, m.c, m.o);
      end
    end
    drain();

    m = model(32'h7FFF0000, 32'h00010000, 1'b0, 1'b1);
    issue(32'h7FFF0000, 32'h00010000, 1'b0, 1'b1, m.r, m.c, m.o);
    idle_or_stall(1'b0);
    m = model(32'h00000010, 32'h00000020, 1'b1, 1'b1);
    issue(32'h00000010, 32'h00000020, 1'b1, 1'b1, m.r, m.c, m.o);
    repeat (3) idle_or_stall(1'b1);
    bus.i_valid = 1'b0;
    bus.i_stall = 1'b0;
    np  = 0;
    pat = 3'b000;
    for (int t = 0; t < 20 && np < 3; t++) begin
      @(negedge clk);
      if (!last_stalled && (np > 0 || bus.o_valid === 1'b1)) begin
        pat[2-np] = bus.o_valid;
        np++;
      end
    end
    check("stall_valid_pattern", {29'd0, pat}, 32'b101);
    drain();

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h11111111 * 32'(i + 1);
      m = model(a, 32'h22222222, 1'b0, 1'b0);
      issue(a, 32'h22222222, 1'b0, 1'b0, m.r, m.c, m.o);
    end
    bus.i_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_valid", 32'(bus.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus.o_valid), 32'd0);
    check("async_reset_result", bus.o_result, 32'd0);
    check("async_reset_carry", 32'(bus.o_carry), 32'd0);
    check("async_reset_overflow", 32'(bus.o_overflow), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m = model(32'hFFFF0000, 32'h00010001, 1'b0, 1'b0);
    issue(32'hFFFF0000, 32'h00010001, 1'b0, 1'b0, m.r, m.c, m.o);
    drain();
    repeat (6) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
